// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encodings, parity modes, counter widths.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    // Receive FSM state encodings
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Value of parity_odd selecting each parity mode
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rx pin plus falling-edge detect on the synchronised line.
// Latency: rx_s follows rx by 2 clk; fall is asserted combinationally in the cycle rx_s first reads 0.
// Backpressure: none; free-running, every flop resets to the idle (high) line level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic sync_1;
    logic rx_s_d;

    // Metastability chain and one-cycle history of the synchronised line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            sync_1 <= rx;
            rx_s   <= sync_1;
            rx_s_d <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling, shift register, optional parity and stop checks.
// Latency: busy 3 clk after rx falls; rx_valid/parity_err/frame_err 1 clk after the final stop decision tick.
// Backpressure: none; each word is presented for one cycle. Parity is compiled in with UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 sample_tick,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int OS_W  = cnt_width(OVERSAMPLE);
    localparam int BIT_W = cnt_width(DATA_BITS + 1);

    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    rx_state_t            state,     state_nxt;
    logic [OS_W-1:0]      os_cnt,    os_cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt,   bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q,   shift_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 frame_err_nxt;
    logic                 parity_err_nxt;

`ifdef UART_RX_PARITY_EN
    // Parity verdict held from the parity sample until the stop decision
    logic                 par_bad, par_bad_nxt;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            os_cnt     <= os_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_q    <= shift_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            frame_err  <= frame_err_nxt;
            busy       <= (state_nxt != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Next-state and datapath: counters move only on sample_tick, decisions fall on mid-bit ticks
    always_comb begin
        state_nxt      = state;
        os_cnt_nxt     = os_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift_q;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt    = par_bad;
`endif

        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_nxt  = ST_START;
                    os_cnt_nxt = '0;
                end
            end

            ST_START: begin
                if (sample_tick) begin
                    if (os_cnt == OS_MID) begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (!rx_s) begin
                            state_nxt   = ST_DATA;
                            os_cnt_nxt  = '0;
                            bit_cnt_nxt = '0;
                        end else begin
                            state_nxt   = ST_IDLE;
                        end
                    end else begin
                        os_cnt_nxt = os_cnt + OS_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (sample_tick) begin
                    if (os_cnt == OS_LAST) begin
                        shift_nxt  = {rx_s, shift_q[DATA_BITS-1:1]};
                        os_cnt_nxt = '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            state_nxt   = ST_PARITY;
`else
                            state_nxt   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_nxt = os_cnt + OS_W'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_tick) begin
                    if (os_cnt == OS_LAST) begin
                        par_bad_nxt = (^shift_q) ^ rx_s ^ (parity_odd == PAR_ODD);
                        state_nxt   = ST_STOP;
                        os_cnt_nxt  = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        os_cnt_nxt = os_cnt + OS_W'(1);
                    end
                end
            end
`endif

            ST_STOP: begin
                if (sample_tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_nxt = '0;
                        if (!rx_s) begin
                            // Framing error wins: word and parity verdict are dropped
                            state_nxt     = ST_IDLE;
                            frame_err_nxt = 1'b1;
                        end else if (bit_cnt == STOP_LAST) begin
                            state_nxt    = ST_IDLE;
                            rx_data_nxt  = shift_q;
                            rx_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_nxt = par_bad;
`endif
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_nxt = os_cnt + OS_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int OS  = 16;
    localparam int TPT = 4;          // clk per sample_tick
    localparam int CPB = OS * TPT;   // clk per bit

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick = 1'b0;
    logic       parity_odd;
    logic       rx_a, rx_b;

    logic [7:0] rx_data_a;
    logic       rx_valid_a, parity_err_a, frame_err_a, busy_a;
    logic [6:0] rx_data_b;
    logic       rx_valid_b, parity_err_b, frame_err_b, busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Free-running oversample tick: one clk high every TPT clks
    int tdiv = 0;
    always @(posedge clk) begin
        tdiv        <= (tdiv == TPT - 1) ? 0 : tdiv + 1;
        sample_tick <= (tdiv == TPT - 1);
    end

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_a),
        .sample_tick (sample_tick),
        .parity_odd  (parity_odd),
        .rx_data     (rx_data_a),
        .rx_valid    (rx_valid_a),
        .parity_err  (parity_err_a),
        .frame_err   (frame_err_a),
        .busy        (busy_a)
    );

    uart_rx_ctrl #(.DATA_BITS(7), .OVERSAMPLE(OS), .STOP_BITS(2)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_b),
        .sample_tick (sample_tick),
        .parity_odd  (parity_odd),
        .rx_data     (rx_data_b),
        .rx_valid    (rx_valid_b),
        .parity_err  (parity_err_b),
        .frame_err   (frame_err_b),
        .busy        (busy_b)
    );

    // Output monitors, sampled on the falling edge
    int         va_cnt = 0, fa_cnt = 0, pa_orphan = 0, flag_busy_a = 0, dbl_a = 0;
    logic [7:0] last_a_data = '0;
    logic       last_a_perr = 1'b0;
    logic       prev_va = 1'b0;
    int         vb_cnt = 0, fb_cnt = 0;
    logic [6:0] b_data_q[$];
    bit         busy_low_flag = 1'b0;

    always @(negedge clk) begin
        if (rx_valid_a) begin
            va_cnt++;
            last_a_data = rx_data_a;
            last_a_perr = parity_err_a;
            if (prev_va) dbl_a++;
        end
        if (parity_err_a && !rx_valid_a) pa_orphan++;
        if (frame_err_a) fa_cnt++;
        if ((rx_valid_a || frame_err_a) && busy_a) flag_busy_a++;
        prev_va = rx_valid_a;
        if (rx_valid_b) begin
            vb_cnt++;
            b_data_q.push_back(rx_data_b);
        end
        if (frame_err_b) fb_cnt++;
    end

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
        repeat (CPB / 4) @(negedge clk);
        if ((sel ? busy_b : busy_a) !== 1'b1) busy_low_flag = 1'b1;
        repeat (CPB - CPB / 4) @(negedge clk);
    endtask

    task automatic idle_bits(input bit sel, input int n);
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // par_bit < 0 sends the correct parity bit for the current parity_odd
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input int nstop, input logic stop_val, input int par_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
`ifdef UART_RX_PARITY_EN
        if (par_bit < 0) drive_bit(sel, (^data) ^ parity_odd);
        else             drive_bit(sel, par_bit[0]);
`endif
        for (int i = 0; i < nstop; i++) drive_bit(sel, stop_val);
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data_a !== 8'h00) begin failures++; $display("FAIL reset_rx_data_a got=%h exp=00", rx_data_a); end
        checks++; if (rx_valid_a !== 1'b0) begin failures++; $display("FAIL reset_rx_valid_a got=%b exp=0", rx_valid_a); end
        checks++; if (parity_err_a !== 1'b0) begin failures++; $display("FAIL reset_parity_err_a got=%b exp=0", parity_err_a); end
        checks++; if (frame_err_a !== 1'b0) begin failures++; $display("FAIL reset_frame_err_a got=%b exp=0", frame_err_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
        checks++; if (rx_data_b !== 7'h00) begin failures++; $display("FAIL reset_rx_data_b got=%h exp=00", rx_data_b); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy_b got=%b exp=0", busy_b); end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = va_cnt; f0 = fa_cnt;
        rx_a = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL start_latency_2clk busy got=%b exp=0", busy_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL start_latency_3clk busy got=%b exp=1", busy_a); end
        repeat (4 * TPT - 3) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL glitch_busy_during_low got=%b exp=1", busy_a); end
        rx_a = 1'b1;
        repeat (CPB) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_busy_after got=%b exp=0", busy_a); end
        checks++; if (va_cnt !== v0) begin failures++; $display("FAIL glitch_valid_count got=%0d exp=%0d", va_cnt, v0); end
        checks++; if (fa_cnt !== f0) begin failures++; $display("FAIL glitch_frame_err_count got=%0d exp=%0d", fa_cnt, f0); end
    endtask

    task automatic test_basic;
        int v0, f0;
        v0 = va_cnt; f0 = fa_cnt; busy_low_flag = 1'b0;
        send_frame(1'b0, 9'h0A5, 8, 1, 1'b1, -1);
        idle_bits(1'b0, 1);
        checks++; if (va_cnt !== v0 + 1) begin failures++; $display("FAIL basic_valid_count got=%0d exp=%0d", va_cnt, v0 + 1); end
        checks++; if (last_a_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", last_a_data); end
        checks++; if (last_a_perr !== 1'b0) begin failures++; $display("FAIL basic_parity_err got=%b exp=0", last_a_perr); end
        checks++; if (fa_cnt !== f0) begin failures++; $display("FAIL basic_frame_err got=%0d exp=%0d", fa_cnt, f0); end
        checks++; if (busy_low_flag !== 1'b0) begin failures++; $display("FAIL basic_busy_in_frame got_low=%b exp=0", busy_low_flag); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy_a); end
        checks++; if (flag_busy_a !== 0) begin failures++; $display("FAIL basic_busy_at_flag got=%0d exp=0", flag_busy_a); end
        checks++; if (dbl_a !== 0) begin failures++; $display("FAIL basic_valid_width got=%0d long pulses exp=0", dbl_a); end
    endtask

    task automatic test_parity;
        int v0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        v0 = va_cnt;
        send_frame(1'b0, 9'h03C, 8, 1, 1'b1, 1);
        idle_bits(1'b0, 1);
        checks++; if (va_cnt !== v0 + 1) begin failures++; $display("FAIL par_even_bad_valid got=%0d exp=%0d", va_cnt, v0 + 1); end
        checks++; if (last_a_data !== 8'h3C) begin failures++; $display("FAIL par_even_bad_data got=%h exp=3c", last_a_data); end
        checks++; if (last_a_perr !== 1'b1) begin failures++; $display("FAIL par_even_bad_perr got=%b exp=1", last_a_perr); end
        send_frame(1'b0, 9'h03C, 8, 1, 1'b1, 0);
        idle_bits(1'b0, 1);
        checks++; if (last_a_perr !== 1'b0) begin failures++; $display("FAIL par_even_good_perr got=%b exp=0", last_a_perr); end
        parity_odd = 1'b1;
        send_frame(1'b0, 9'h03C, 8, 1, 1'b1, 0);
        idle_bits(1'b0, 1);
        checks++; if (last_a_perr !== 1'b1) begin failures++; $display("FAIL par_odd_bad_perr got=%b exp=1", last_a_perr); end
        checks++; if (va_cnt !== v0 + 3) begin failures++; $display("FAIL par_valid_total got=%0d exp=%0d", va_cnt, v0 + 3); end
        parity_odd = 1'b0;
`else
        parity_odd = 1'b1;
        v0 = va_cnt;
        send_frame(1'b0, 9'h03C, 8, 1, 1'b1, -1);
        idle_bits(1'b0, 1);
        checks++; if (va_cnt !== v0 + 1) begin failures++; $display("FAIL nopar_valid got=%0d exp=%0d", va_cnt, v0 + 1); end
        checks++; if (last_a_data !== 8'h3C) begin failures++; $display("FAIL nopar_data got=%h exp=3c", last_a_data); end
        checks++; if (last_a_perr !== 1'b0) begin failures++; $display("FAIL nopar_perr got=%b exp=0", last_a_perr); end
        parity_odd = 1'b0;
`endif
        checks++; if (pa_orphan !== 0) begin failures++; $display("FAIL parity_without_valid got=%0d exp=0", pa_orphan); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = va_cnt; f0 = fa_cnt;
        send_frame(1'b0, 9'h055, 8, 1, 1'b0, -1);
        idle_bits(1'b0, 2);
        checks++; if (fa_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_count got=%0d exp=%0d", fa_cnt, f0 + 1); end
        checks++; if (va_cnt !== v0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=%0d", va_cnt, v0); end
        checks++; if (rx_data_a !== 8'h3C) begin failures++; $display("FAIL ferr_data_kept got=%h exp=3c", rx_data_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy_a); end
        checks++; if (flag_busy_a !== 0) begin failures++; $display("FAIL ferr_busy_at_flag got=%0d exp=0", flag_busy_a); end
        send_frame(1'b0, 9'h00F, 8, 1, 1'b1, -1);
        idle_bits(1'b0, 1);
        checks++; if (va_cnt !== v0 + 1) begin failures++; $display("FAIL ferr_next_valid got=%0d exp=%0d", va_cnt, v0 + 1); end
        checks++; if (last_a_data !== 8'h0F) begin failures++; $display("FAIL ferr_next_data got=%h exp=0f", last_a_data); end
        checks++; if (fa_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_next_no_ferr got=%0d exp=%0d", fa_cnt, f0 + 1); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] d;
        parity_odd = 1'b0;
        send_frame(1'b1, 9'h041, 7, 2, 1'b1, -1);
        send_frame(1'b1, 9'h07F, 7, 2, 1'b1, -1);
        idle_bits(1'b1, 2);
        checks++; if (vb_cnt !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", vb_cnt); end
        checks++; if (fb_cnt !== 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", fb_cnt); end
        d = (b_data_q.size() > 0) ? b_data_q.pop_front() : 7'h00;
        checks++; if (d !== 7'h41) begin failures++; $display("FAIL b2b_first got=%h exp=41", d); end
        d = (b_data_q.size() > 0) ? b_data_q.pop_front() : 7'h00;
        checks++; if (d !== 7'h7F) begin failures++; $display("FAIL b2b_second got=%h exp=7f", d); end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        logic [7:0] pat;
        pat = 8'hF0;
        v0 = va_cnt; f0 = fa_cnt;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, pat[i]);
        rx_a = pat[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rx_data_a !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", rx_data_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
        checks++; if ({rx_valid_a, frame_err_a, parity_err_a} !== 3'b000) begin failures++; $display("FAIL rstmid_flags got=%b exp=000", {rx_valid_a, frame_err_a, parity_err_a}); end
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle_bits(1'b0, 1);
        send_frame(1'b0, 9'h081, 8, 1, 1'b1, -1);
        idle_bits(1'b0, 1);
        checks++; if (va_cnt !== v0 + 1) begin failures++; $display("FAIL rstmid_next_valid got=%0d exp=%0d", va_cnt, v0 + 1); end
        checks++; if (last_a_data !== 8'h81) begin failures++; $display("FAIL rstmid_next_data got=%h exp=81", last_a_data); end
        checks++; if (fa_cnt !== f0) begin failures++; $display("FAIL rstmid_no_ferr got=%0d exp=%0d", fa_cnt, f0); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_basic();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
